// File: rtl/vga_fb_scanout.sv
// VGA timing generator with scaled framebuffer scan-out and 3-3-2 RGB output.
// Optional palette: define PALETTE_EN to replace the fixed FG/BG colours with 4 writable entries.
module vga_fb_scanout #(
  parameter int          H_ACTIVE    = 640,
  parameter int          H_FRONT     = 16,
  parameter int          H_SYNC      = 96,
  parameter int          H_BACK      = 48,
  parameter int          V_ACTIVE    = 400,
  parameter int          V_FRONT     = 12,
  parameter int          V_SYNC      = 2,
  parameter int          V_BACK      = 35,
  parameter logic        HS_POL      = 1'b0,
  parameter logic        VS_POL      = 1'b1,
  parameter int          SCALE_SHIFT = 1,
  parameter int          XW          = 9,
  parameter int          YW          = 8,
  parameter int          PIX_W       = 1,
  parameter logic [7:0]  FG          = 8'hFF,
  parameter logic [7:0]  BG          = 8'h25
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [PIX_W-1:0] i_pix_in,
`ifdef PALETTE_EN
  input  logic             i_pal_we,
  input  logic [1:0]       i_pal_addr,
  input  logic [7:0]       i_pal_data,
`endif
  output logic             o_hs,
  output logic             o_vs,
  output logic [2:0]       o_r,
  output logic [2:0]       o_g,
  output logic [1:0]       o_b,
  output logic [XW-1:0]    o_x_a,
  output logic [YW-1:0]    o_y_a,
  output logic             o_frame_start,
  output logic             o_vblank
);

  localparam int H_TOTAL = H_FRONT + H_SYNC + H_BACK + H_ACTIVE;
  localparam int H_BLANK = H_TOTAL - H_ACTIVE;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  logic [HW-1:0] r_h;
  logic [VW-1:0] r_v;
  logic [31:0]   w_h;
  logic [31:0]   w_v;
  logic [31:0]   w_xFull;
  logic [31:0]   w_yFull;
  logic          w_active;
  logic          w_vActive;
  logic          w_hs;
  logic          w_vs;
  logic          w_fs;
  logic [7:0]    w_colour;

  logic [XW-1:0] r_xa;
  logic [YW-1:0] r_ya;
  logic [1:0]    r_actD;
  logic [2:0]    r_hsD;
  logic [2:0]    r_vsD;
  logic [2:0]    r_vbD;
  logic [2:0]    r_fsD;
  logic [7:0]    r_rgb;

  assign w_h = 32'(r_h);
  assign w_v = 32'(r_v);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_h <= '0;
      r_v <= '0;
    end else if (w_h == H_TOTAL - 1) begin
      r_h <= '0;
      r_v <= (w_v == V_TOTAL - 1) ? '0 : r_v + VW'(1);
    end else begin
      r_h <= r_h + HW'(1);
    end
  end

  assign w_vActive = (w_v < V_ACTIVE);
  assign w_active  = (w_h >= H_BLANK) && w_vActive;
  assign w_xFull   = (w_h - H_BLANK) >> SCALE_SHIFT;
  assign w_yFull   = w_v >> SCALE_SHIFT;
  assign w_hs      = ((w_h >= H_FRONT) && (w_h < H_FRONT + H_SYNC)) ? HS_POL : ~HS_POL;
  assign w_vs      = ((w_v >= V_ACTIVE + V_FRONT) && (w_v < V_ACTIVE + V_FRONT + V_SYNC))
                     ? VS_POL : ~VS_POL;
  assign w_fs      = (w_h == H_BLANK) && (w_v == 0);

`ifdef PALETTE_EN
  logic [7:0] r_pal [4];

  // A write to the entry being read lands at this edge, so the pixel still shows the old colour
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pal[0] <= BG;
      r_pal[1] <= FG;
      r_pal[2] <= 8'h00;
      r_pal[3] <= 8'hFF;
    end else if (i_pal_we) begin
      r_pal[i_pal_addr] <= i_pal_data;
    end
  end

  assign w_colour = r_pal[i_pix_in[1:0]];
`else
  assign w_colour = i_pix_in[0] ? FG : BG;
`endif

  // Syncs and flags ride a 3-deep delay so they line up with the RAM-latency pixel path
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_xa   <= '0;
      r_ya   <= '0;
      r_actD <= '0;
      r_hsD  <= {3{~HS_POL}};
      r_vsD  <= {3{~VS_POL}};
      r_vbD  <= '0;
      r_fsD  <= '0;
      r_rgb  <= '0;
    end else begin
      r_xa   <= w_active ? XW'(w_xFull) : '0;
      r_ya   <= w_vActive ? YW'(w_yFull) : '0;
      r_actD <= {r_actD[0], w_active};
      r_hsD  <= {r_hsD[1:0], w_hs};
      r_vsD  <= {r_vsD[1:0], w_vs};
      r_vbD  <= {r_vbD[1:0], ~w_vActive};
      r_fsD  <= {r_fsD[1:0], w_fs};
      r_rgb  <= r_actD[1] ? w_colour : 8'h00;
    end
  end

  assign o_x_a         = r_xa;
  assign o_y_a         = r_ya;
  assign o_hs          = r_hsD[2];
  assign o_vs          = r_vsD[2];
  assign o_vblank      = r_vbD[2];
  assign o_frame_start = r_fsD[2];
  assign o_r           = r_rgb[7:5];
  assign o_g           = r_rgb[4:2];
  assign o_b           = r_rgb[1:0];

endmodule

// File: tb/tb_vga_fb_scanout.sv
// Directed bench for vga_fb_scanout: a default-width instance with a short frame and a tiny instance.
// Build with PALETTE_EN defined to also exercise the palette write path.
module tb_vga_fb_scanout;

`ifdef PALETTE_EN
  localparam int PW = 2;
`else
  localparam int PW = 1;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;

  logic          mHs, mVs, mFs, mVb;
  logic [2:0]    mR, mG;
  logic [1:0]    mB;
  logic [8:0]    mXa;
  logic [7:0]    mYa;
  logic [PW-1:0] mPix = '0;

  logic          sHs, sVs, sFs, sVb;
  logic [2:0]    sR, sG;
  logic [1:0]    sB;
  logic [8:0]    sXa;
  logic [7:0]    sYa;
  logic [PW-1:0] sPix = '1;

  logic          palWe   = 1'b0;
  logic [1:0]    palAddr = 2'd0;
  logic [7:0]    palData = 8'h00;

  int   checkCount = 0;
  int   errorCount = 0;
  int   cyc = 0;
  int   pixMode = 0;
  logic prevBit = 1'b0;

  vga_fb_scanout #(
    .V_ACTIVE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(2), .PIX_W(PW)
  ) dutMain (
    .i_clk(clk), .i_rst(rst), .i_pix_in(mPix),
`ifdef PALETTE_EN
    .i_pal_we(palWe), .i_pal_addr(palAddr), .i_pal_data(palData),
`endif
    .o_hs(mHs), .o_vs(mVs), .o_r(mR), .o_g(mG), .o_b(mB),
    .o_x_a(mXa), .o_y_a(mYa), .o_frame_start(mFs), .o_vblank(mVb)
  );

  vga_fb_scanout #(
    .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(4),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .SCALE_SHIFT(0), .PIX_W(PW)
  ) dutSmall (
    .i_clk(clk), .i_rst(rst), .i_pix_in(sPix),
`ifdef PALETTE_EN
    .i_pal_we(1'b0), .i_pal_addr(2'd0), .i_pal_data(8'h00),
`endif
    .o_hs(sHs), .o_vs(sVs), .o_r(sR), .o_g(sG), .o_b(sB),
    .o_x_a(sXa), .o_y_a(sYa), .o_frame_start(sFs), .o_vblank(sVb)
  );

  always #5 clk = ~clk;

  // cyc equals the counter value the DUTs hold after each edge
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // Sync-read framebuffer model: pix = x_a[0]^y_a[0], one clock behind the address
  initial begin
    forever begin
      @(negedge clk);
      if (pixMode == 2) mPix = PW'(2);
      else              mPix = PW'(prevBit);
      prevBit = mXa[0] ^ mYa[0];
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic rstVal);
    rst = rstVal;
  endtask

  task automatic waitCyc(input int n);
    int guard = 0;
    while (cyc < n && guard < 30000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    checkOutput("cycle", cyc, n);
  endtask

  initial begin
    applyStimulus(1'b1);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_hs", mHs, 1);
    checkOutput("rst_vs", mVs, 0);
    checkOutput("rst_rgb", {mR, mG, mB}, 8'h00);
    checkOutput("rst_xa", mXa, 0);
    checkOutput("rst_ya", mYa, 0);
    checkOutput("rst_fs", mFs, 0);
    checkOutput("rst_vb", mVb, 0);
    checkOutput("rst_s_hs", sHs, 1);
    checkOutput("rst_s_vs", sVs, 0);
    applyStimulus(1'b0);

    waitCyc(4);  checkOutput("s_hs_pre", sHs, 1);
    waitCyc(5);  checkOutput("s_hs_on", sHs, 0);
    waitCyc(7);  checkOutput("s_hs_off", sHs, 1);
    waitCyc(10); checkOutput("s_rgb_blank", {sR, sG, sB}, 8'h00);
    waitCyc(11);
    checkOutput("s_rgb_first", {sR, sG, sB}, 8'hFF);
    checkOutput("s_fs", sFs, 1);
    checkOutput("s_xa2", sXa, 2);
    waitCyc(16); checkOutput("s_xa7", sXa, 7);
    waitCyc(18); checkOutput("m_hs_pre", mHs, 1);
    waitCyc(19); checkOutput("m_hs_fall", mHs, 0);
    waitCyc(21); checkOutput("s_hs_line1", sHs, 0);
    waitCyc(27); checkOutput("s_fs_line1", sFs, 0);
    waitCyc(62); checkOutput("s_ya3", sYa, 3);
    waitCyc(66); checkOutput("s_vb_pre", sVb, 0);
    waitCyc(67); checkOutput("s_vb_on", sVb, 1);
    waitCyc(78);
    checkOutput("s_ya_vblank", sYa, 0);
    checkOutput("s_xa_vblank", sXa, 0);
    waitCyc(82); checkOutput("s_vs_pre", sVs, 0);
    waitCyc(83); checkOutput("s_vs_on", sVs, 1);
    waitCyc(99); checkOutput("s_vs_off", sVs, 0);
    waitCyc(100);
    checkOutput("m_rgb_hblank", {mR, mG, mB}, 8'h00);
    checkOutput("m_xa_hblank", mXa, 0);
    waitCyc(114); checkOutput("m_hs_last", mHs, 0);
    waitCyc(115);
    checkOutput("m_hs_rise", mHs, 1);
    checkOutput("s_vb_wrap", sVb, 0);
    waitCyc(123); checkOutput("s_fs_wrap", sFs, 1);
    waitCyc(162); checkOutput("m_fs_pre", mFs, 0);
    waitCyc(163);
    checkOutput("m_fs", mFs, 1);
    checkOutput("m_rgb_x0", {mR, mG, mB}, 8'h25);
    waitCyc(164);
    checkOutput("m_fs_post", mFs, 0);
    checkOutput("m_rgb_x0b", {mR, mG, mB}, 8'h25);
    waitCyc(165); checkOutput("m_rgb_x1", {mR, mG, mB}, 8'hFF);
    waitCyc(167); checkOutput("m_rgb_x2", {mR, mG, mB}, 8'h25);
    waitCyc(800);
    checkOutput("m_xa_max", mXa, 319);
    checkOutput("m_ya_line0", mYa, 0);
    waitCyc(963);  checkOutput("m_rgb_v1", {mR, mG, mB}, 8'h25);
    waitCyc(1763); checkOutput("m_rgb_v2x0", {mR, mG, mB}, 8'hFF);
    waitCyc(1765); checkOutput("m_rgb_v2x1", {mR, mG, mB}, 8'h25);
    waitCyc(4500);
    checkOutput("m_xa169", mXa, 169);
    checkOutput("m_ya2", mYa, 2);
    checkOutput("m_rgb_v5", {mR, mG, mB}, 8'h25);
    waitCyc(4802); checkOutput("m_vb_pre", mVb, 0);
    waitCyc(4803); checkOutput("m_vb_on", mVb, 1);
    waitCyc(5000);
    checkOutput("m_xa_vblank", mXa, 0);
    checkOutput("m_ya_vblank", mYa, 0);
    checkOutput("m_rgb_vblank", {mR, mG, mB}, 8'h00);
    waitCyc(6402); checkOutput("m_vs_pre", mVs, 0);
    waitCyc(6403); checkOutput("m_vs_on", mVs, 1);
    waitCyc(8002); checkOutput("m_vs_last", mVs, 1);
    waitCyc(8003); checkOutput("m_vs_off", mVs, 0);
    waitCyc(9603); checkOutput("m_vb_wrap", mVb, 0);
    waitCyc(9762); checkOutput("m_fs2_pre", mFs, 0);
    waitCyc(9763); checkOutput("m_fs2", mFs, 1);

    // Mid-line reset with the counter at (400,1) of the second frame
    waitCyc(10800);
    checkOutput("m_rgb_prerst", {mR, mG, mB}, 8'h25);
    applyStimulus(1'b1);
    @(posedge clk);
    #1;
    checkOutput("mrst_rgb", {mR, mG, mB}, 8'h00);
    checkOutput("mrst_hs", mHs, 1);
    checkOutput("mrst_vs", mVs, 0);
    checkOutput("mrst_xa", mXa, 0);
    checkOutput("mrst_fs", mFs, 0);
    applyStimulus(1'b0);
    for (int k = 1; k <= 3; k++) begin
      waitCyc(k);
      checkOutput("flush_rgb", {mR, mG, mB}, 8'h00);
      checkOutput("flush_hs", mHs, 1);
      checkOutput("flush_vs", mVs, 0);
    end
    waitCyc(18);  checkOutput("re_hs_pre", mHs, 1);
    waitCyc(19);  checkOutput("re_hs_fall", mHs, 0);
    waitCyc(163); checkOutput("re_fs", mFs, 1);

`ifdef PALETTE_EN
    pixMode = 2;
    waitCyc(250);
    palWe   = 1'b1;
    palAddr = 2'd2;
    palData = 8'hE0;
    waitCyc(251);
    palWe = 1'b0;
    checkOutput("pal_old", {mR, mG, mB}, 8'h00);
    waitCyc(252);
    checkOutput("pal_new", {mR, mG, mB}, 8'hE0);
    checkOutput("pal_r", mR, 7);
    checkOutput("pal_g", mG, 0);
    checkOutput("pal_b", mB, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
